// File: rtl/csr_regfile_if.sv
// CSR strobe bundle between the AXI4-Lite CSR slave and csr_regfile.
// master = slave-side bus bridge, slave = register file.
interface csr_regfile_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              csr_wen;
    logic              csr_ren;
    logic [ADDR_W-1:0] csr_addr;
    logic [DATA_W-1:0] csr_wdata;
    logic [DATA_W-1:0] csr_rdata;

    modport master (
        output csr_wen, csr_ren, csr_addr, csr_wdata,
        input  csr_rdata
    );

    modport slave (
        input  csr_wen, csr_ren, csr_addr, csr_wdata,
        output csr_rdata
    );
endinterface

// File: rtl/csr_regfile.sv
// Accelerator control/status register file: job config, start/soft-reset
// pulses, sticky status, cycle counter, irq. CSR_PERF_EN adds STALL_CNT.
module csr_regfile #(
    parameter int          ADDR_W  = 8,
    parameter int          DATA_W  = 32,
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic         clk,
    input  logic         rst,
    csr_regfile_if.slave bus,
    output logic         core_start,
    output logic         core_soft_rst,
    input  logic         core_busy,
    input  logic         core_done,
    input  logic         core_err,
    input  logic         core_stall,
    output logic [31:0]  cfg_img_base,
    output logic [31:0]  cfg_wgt_base,
    output logic [31:0]  cfg_out_base,
    output logic [15:0]  cfg_rows,
    output logic [15:0]  cfg_cols,
    output logic         irq
);
    localparam int W = ADDR_W - 2;

    localparam logic [W-1:0] A_CTRL   = W'(0);
    localparam logic [W-1:0] A_STATUS = W'(1);
    localparam logic [W-1:0] A_IMG    = W'(2);
    localparam logic [W-1:0] A_WGT    = W'(3);
    localparam logic [W-1:0] A_OUT    = W'(4);
    localparam logic [W-1:0] A_DIMS   = W'(5);
    localparam logic [W-1:0] A_CYCLE  = W'(6);
    localparam logic [W-1:0] A_VER    = W'(7);
    localparam logic [W-1:0] A_SCR    = W'(8);
    localparam logic [W-1:0] A_STALL  = W'(9);

    logic [W-1:0] widx;
    logic [31:0]  wdata;
    logic [31:0]  rd;

    logic         irq_en;
    logic         done;
    logic         err;
    logic         start_pending;
    logic [31:0]  cycle_cnt;
    logic [31:0]  scratch;

    logic         busy;
    logic         wr_ctrl;
    logic         wr_status;
    logic         soft_req;
    logic         start_req;
    logic         start_ok;
    logic         start_bad;
    logic         w1c_done;
    logic         w1c_err;

    assign widx  = bus.csr_addr[ADDR_W-1:2];
    assign wdata = bus.csr_wdata[31:0];
    assign busy  = core_busy | start_pending;

    // Decode write strobes; SOFT_RST masks START in the same word
    always_comb begin
        wr_ctrl   = bus.csr_wen && (widx == A_CTRL);
        wr_status = bus.csr_wen && (widx == A_STATUS);
        soft_req  = wr_ctrl && wdata[1];
        start_req = wr_ctrl && wdata[0] && !wdata[1];
        start_ok  = start_req && !busy;
        start_bad = start_req && busy;
        w1c_done  = wr_status && wdata[1];
        w1c_err   = wr_status && wdata[2];
    end

    // Software-visible configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en       <= 1'b0;
            cfg_img_base <= '0;
            cfg_wgt_base <= '0;
            cfg_out_base <= '0;
            cfg_rows     <= '0;
            cfg_cols     <= '0;
            scratch      <= '0;
        end else if (bus.csr_wen) begin
            case (widx)
                A_CTRL: irq_en       <= wdata[2];
                A_IMG:  cfg_img_base <= wdata;
                A_WGT:  cfg_wgt_base <= wdata;
                A_OUT:  cfg_out_base <= wdata;
                A_DIMS: begin
                    cfg_rows <= wdata[15:0];
                    cfg_cols <= wdata[31:16];
                end
                A_SCR:  scratch <= wdata;
                default: ;
            endcase
        end
    end

    // Pulses, sticky status and the pending-start flag
    always_ff @(posedge clk) begin
        if (rst) begin
            core_start    <= 1'b0;
            core_soft_rst <= 1'b0;
            irq           <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            start_pending <= 1'b0;
        end else begin
            core_start    <= start_ok;
            core_soft_rst <= soft_req;
            irq           <= irq_en & (done | err);
            if (soft_req) begin
                done          <= 1'b0;
                err           <= 1'b0;
                start_pending <= 1'b0;
            end else begin
                done <= (done & ~w1c_done & ~start_ok) | core_done;
                err  <= (err & ~w1c_err) | core_err | start_bad;
                if (start_ok)
                    start_pending <= 1'b1;
                else if (core_busy || core_done)
                    start_pending <= 1'b0;
            end
        end
    end

    // Saturating job cycle counter
    always_ff @(posedge clk) begin
        if (rst || soft_req || start_ok)
            cycle_cnt <= '0;
        else if (busy && cycle_cnt != 32'hFFFF_FFFF)
            cycle_cnt <= cycle_cnt + 32'd1;
    end

`ifdef CSR_PERF_EN
    logic [31:0] stall_cnt;

    // Saturating count of busy cycles spent stalled on memory
    always_ff @(posedge clk) begin
        if (rst || soft_req || start_ok)
            stall_cnt <= '0;
        else if (busy && core_stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end

    logic unused_ok;
    assign unused_ok = ^{bus.csr_ren, bus.csr_addr[1:0]};
`else
    logic unused_ok;
    assign unused_ok = ^{bus.csr_ren, bus.csr_addr[1:0], core_stall};
`endif

    // Combinational read mux; reads have no side effects
    always_comb begin
        rd = '0;
        case (widx)
            A_CTRL:   rd = {29'd0, irq_en, 2'b00};
            A_STATUS: rd = {29'd0, err, done, busy};
            A_IMG:    rd = cfg_img_base;
            A_WGT:    rd = cfg_wgt_base;
            A_OUT:    rd = cfg_out_base;
            A_DIMS:   rd = {cfg_cols, cfg_rows};
            A_CYCLE:  rd = cycle_cnt;
            A_VER:    rd = VERSION;
            A_SCR:    rd = scratch;
            A_STALL: begin
`ifdef CSR_PERF_EN
                rd = stall_cnt;
`else
                rd = '0;
`endif
            end
            default:  rd = '0;
        endcase
    end

    assign bus.csr_rdata = DATA_W'(rd);
endmodule

// File: tb/tb_csr_regfile.sv
// Directed + randomized bench for csr_regfile with an address-level
// register model for the random phase.
module tb_csr_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        core_start;
    logic        core_soft_rst;
    logic        core_busy;
    logic        core_done;
    logic        core_err;
    logic        core_stall;
    logic [31:0] cfg_img_base;
    logic [31:0] cfg_wgt_base;
    logic [31:0] cfg_out_base;
    logic [15:0] cfg_rows;
    logic [15:0] cfg_cols;
    logic        irq;

    int checks = 0;
    int errors = 0;

`ifdef CSR_PERF_EN
    localparam logic [31:0] STALL_EXP = 32'd7;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
`endif

    csr_regfile_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    csr_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .core_start    (core_start),
        .core_soft_rst (core_soft_rst),
        .core_busy     (core_busy),
        .core_done     (core_done),
        .core_err      (core_err),
        .core_stall    (core_stall),
        .cfg_img_base  (cfg_img_base),
        .cfg_wgt_base  (cfg_wgt_base),
        .cfg_out_base  (cfg_out_base),
        .cfg_rows      (cfg_rows),
        .cfg_cols      (cfg_cols),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.csr_addr  = a;
        bus.csr_wdata = d;
        bus.csr_wen   = 1'b1;
        @(negedge clk);
        bus.csr_wen   = 1'b0;
    endtask

    task automatic rdchk(input logic [7:0] a, input logic [31:0] exp,
                         input string tag);
        bus.csr_addr = a;
        bus.csr_ren  = 1'b1;
        #1;
        chk(tag, bus.csr_rdata, exp);
        bus.csr_ren  = 1'b0;
    endtask

    // Random-phase model: RW words by word index, plus CTRL.IRQ_EN
    logic [31:0] rw_model [int];
    logic        ie_model;
    logic [31:0] cyc_model;

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int idx;
        idx = int'(a) / 4;
        if (idx == 0) return {29'd0, ie_model, 2'b00};
        if (idx == 1) return 32'd0;
        if (idx == 6) return cyc_model;
        if (idx == 7) return 32'h0001_0000;
        if (idx == 9) return STALL_EXP;
        if (rw_model.exists(idx)) return rw_model[idx];
        return 32'd0;
    endfunction

    initial begin
        rst = 1'b1;
        core_busy = 1'b0;
        core_done = 1'b0;
        core_err = 1'b0;
        core_stall = 1'b0;
        bus.csr_wen = 1'b0;
        bus.csr_ren = 1'b0;
        bus.csr_addr = '0;
        bus.csr_wdata = '0;
        tick(3);
        rst = 1'b0;
        tick();

        // reset state
        rdchk(8'h1C, 32'h0001_0000, "version");
        rdchk(8'h00, 32'h0, "ctrl_rst");
        rdchk(8'h04, 32'h0, "status_rst");
        chk("irq_rst", irq, 0);
        chk("start_rst", core_start, 0);
        chk("img_rst", cfg_img_base, 0);

        // plain RW and RO write
        wr(8'h08, 32'hDEAD_BEEF);
        chk("img_cfg", cfg_img_base, 32'hDEAD_BEEF);
        rdchk(8'h08, 32'hDEAD_BEEF, "img_rd");
        wr(8'h18, 32'h1234_5678);
        rdchk(8'h18, 32'h0, "cyc_ro");

        // start job
        wr(8'h00, 32'h5);
        chk("start_pulse", core_start, 1);
        rdchk(8'h04, 32'h1, "busy_pending");
        tick();
        chk("start_one", core_start, 0);
        core_busy = 1'b1;
        tick(10);
        core_busy = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        rdchk(8'h04, 32'h2, "done_set");
        rdchk(8'h18, 32'd11, "cyc_11");
        chk("irq_lag", irq, 0);
        tick();
        chk("irq_on", irq, 1);
        rdchk(8'h00, 32'h4, "ctrl_ie");
        wr(8'h04, 32'h2);
        rdchk(8'h04, 32'h0, "done_w1c");
        tick();
        chk("irq_off", irq, 0);

        // start while busy, W1C vs set
        core_busy = 1'b1;
        wr(8'h00, 32'h5);
        chk("no_start", core_start, 0);
        rdchk(8'h04, 32'h5, "err_busy");
        bus.csr_addr = 8'h04;
        bus.csr_wdata = 32'h4;
        bus.csr_wen = 1'b1;
        core_err = 1'b1;
        tick();
        bus.csr_wen = 1'b0;
        core_err = 1'b0;
        rdchk(8'h04, 32'h5, "err_set_wins");
        chk("irq_err", irq, 1);

        // soft reset mid-job, with START in the same word
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        rdchk(8'h04, 32'h7, "done_err");
        wr(8'h00, 32'h3);
        chk("soft_pulse", core_soft_rst, 1);
        chk("soft_nostart", core_start, 0);
        rdchk(8'h18, 32'h0, "soft_cyc");
        rdchk(8'h04, 32'h1, "soft_status");
        rdchk(8'h08, 32'hDEAD_BEEF, "soft_keep_img");
        tick();
        chk("soft_one", core_soft_rst, 0);
        chk("irq_soft", irq, 0);

        // saturation
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_cnt;
        tick(3);
        rdchk(8'h18, 32'hFFFF_FFFF, "cyc_sat");
        core_busy = 1'b0;
        tick();

        // stall counter
        wr(8'h00, 32'h2);
        core_busy = 1'b1;
        core_stall = 1'b1;
        tick(7);
        core_stall = 1'b0;
        tick(13);
        core_busy = 1'b0;
        tick();
        rdchk(8'h18, 32'd20, "cyc_20");
        rdchk(8'h24, STALL_EXP, "stall_cnt");

        // randomized register traffic against the model
        ie_model = 1'b0;
        cyc_model = 32'd20;
        rw_model[2] = 32'hDEAD_BEEF;
        rw_model[3] = 32'h0;
        rw_model[4] = 32'h0;
        rw_model[5] = 32'h0;
        rw_model[8] = 32'h0;
        for (int i = 0; i < 200; i++) begin
            int idx;
            logic [7:0] a;
            logic [31:0] d;
            if ($urandom_range(0, 1) == 1)
                idx = $urandom_range(0, 9);
            else
                idx = $urandom_range(0, 63);
            a = {idx[5:0], 2'($urandom_range(0, 3))};
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                if (idx == 0) d = d & ~32'h3;
                wr(a, d);
                if (idx == 0) ie_model = d[2];
                if (rw_model.exists(idx)) rw_model[idx] = d;
                chk("r_img", cfg_img_base, rw_model[2]);
                chk("r_wgt", cfg_wgt_base, rw_model[3]);
                chk("r_out", cfg_out_base, rw_model[4]);
                chk("r_dims", {cfg_cols, cfg_rows}, rw_model[5]);
                chk("r_pulse", {30'd0, core_start, core_soft_rst}, 0);
            end else begin
                rdchk(a, model_read(a), "r_read");
                tick();
            end
        end
        chk("r_irq", irq, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
